// File: rtl/rle_pkg.sv
// Shared run-length word layout: {value, count}, value in the upper field.
// Used by the packer, the run-length FIFO and the unpacker.
package rle_pkg;

  localparam int VALUE_WIDTH_DEFAULT = 16;
  localparam int COUNT_WIDTH_DEFAULT = 16;
  localparam int DATA_WIDTH_DEFAULT  = VALUE_WIDTH_DEFAULT + COUNT_WIDTH_DEFAULT;

  // Field slices of a DATA_WIDTH word at the default widths
  localparam int VALUE_MSB = DATA_WIDTH_DEFAULT - 1;
  localparam int VALUE_LSB = COUNT_WIDTH_DEFAULT;
  localparam int COUNT_MSB = COUNT_WIDTH_DEFAULT - 1;
  localparam int COUNT_LSB = 0;

  // Largest count a word can carry; a count of 0 is never a legal word
  localparam logic [COUNT_WIDTH_DEFAULT-1:0] COUNT_MAX = '1;

  typedef struct packed {
    logic [VALUE_WIDTH_DEFAULT-1:0] value;
    logic [COUNT_WIDTH_DEFAULT-1:0] count;
  } rle_word_t;

endpackage

// File: rtl/rle_out_slot.sv
// One-entry output register in front of the FIFO: a word loads, then drains
// when the FIFO is not full; a drain and a load in one cycle replace the word.
module rle_out_slot #(
  parameter int DATA_WIDTH = rle_pkg::DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_word,
  input  logic                  full,
  output logic                  enqueue,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  slot_free
);

  logic [DATA_WIDTH-1:0] out_word;

  assign enqueue   = out_valid & ~full;
  assign slot_free = ~out_valid | ~full;
  assign data_out  = out_word;

  // The packer only raises load while slot_free, so a pending word is never overwritten
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_word  <= load_word;
    end else if (enqueue) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rle_packer.sv
// Run-length encoder feeding the run-length FIFO: collapses repeated input
// values into {value, count} words and drives the FIFO enqueue side.
module rle_packer
  import rle_pkg::*;
#(
  parameter int VALUE_WIDTH = VALUE_WIDTH_DEFAULT,
  parameter int COUNT_WIDTH = COUNT_WIDTH_DEFAULT,
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [VALUE_WIDTH-1:0] in_data,
  output logic                   in_ready,
  input  logic                   flush,
  output logic                   flush_done,
  input  logic                   full,
  output logic                   enqueue,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   busy
);

  localparam logic [COUNT_WIDTH-1:0] RUN_MAX = '1;

  logic                   run_active;
  logic [VALUE_WIDTH-1:0] run_value;
  logic [COUNT_WIDTH-1:0] run_count;
  logic                   out_valid;
  logic                   slot_free;
  logic                   flush_pending_emit;
  logic                   accept;
  logic                   extend;
  logic                   close_run;
  logic                   flush_emit;
  logic                   load;
  logic [DATA_WIDTH-1:0]  load_word;

  // Inputs take priority over flush; a flush only acts in an idle input cycle
  assign flush_pending_emit = flush & run_active & ~in_valid;
  assign in_ready           = slot_free & ~flush_pending_emit;
  assign accept             = in_valid & in_ready;
  assign extend             = run_active & (in_data == run_value) & (run_count != RUN_MAX);
  assign close_run          = accept & run_active & ~extend;
  assign flush_emit         = flush_pending_emit & slot_free;
  assign flush_done         = flush & ~in_valid & (~run_active | slot_free);
  assign load               = close_run | flush_emit;
  assign load_word          = {run_value, run_count};
  assign busy               = run_active | out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      run_active <= 1'b0;
      run_value  <= '0;
      run_count  <= '0;
    end else if (accept) begin
      if (extend) begin
        run_count <= run_count + COUNT_WIDTH'(1);
      end else begin
        run_active <= 1'b1;
        run_value  <= in_data;
        run_count  <= COUNT_WIDTH'(1);
      end
    end else if (flush_emit) begin
      run_active <= 1'b0;
    end
  end

  rle_out_slot #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_word (load_word),
    .full      (full),
    .enqueue   (enqueue),
    .data_out  (data_out),
    .out_valid (out_valid),
    .slot_free (slot_free)
  );

endmodule

// File: tb/tb_rle_packer.sv
// Scoreboard bench for rle_packer: directed runs push expected words, a monitor
// pops and compares every enqueued word; a narrow-count instance covers saturation.
module tb_rle_packer;
  import rle_pkg::*;

  localparam int A_VW = VALUE_WIDTH_DEFAULT;
  localparam int A_CW = COUNT_WIDTH_DEFAULT;
  localparam int A_DW = DATA_WIDTH_DEFAULT;
  localparam int B_VW = 28;
  localparam int B_CW = 4;
  localparam int B_DW = 32;

  if (A_DW != A_VW + A_CW) begin : g_bad_width_a
    initial $fatal(1, "[TB] FAIL width_check_a: DATA_WIDTH %0d, VALUE+COUNT %0d", A_DW, A_VW + A_CW);
  end
  if (B_DW != B_VW + B_CW) begin : g_bad_width_b
    initial $fatal(1, "[TB] FAIL width_check_b: DATA_WIDTH %0d, VALUE+COUNT %0d", B_DW, B_VW + B_CW);
  end

  logic            clk;
  logic            reset;
  logic            a_in_valid, a_in_ready, a_flush, a_flush_done, a_full, a_enqueue, a_busy;
  logic [A_VW-1:0] a_in_data;
  logic [A_DW-1:0] a_data_out;
  logic            b_in_valid, b_in_ready, b_flush, b_flush_done, b_full, b_enqueue, b_busy;
  logic [B_VW-1:0] b_in_data;
  logic [B_DW-1:0] b_data_out;

  int          compared;
  int          mismatched;
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  rle_packer #(.VALUE_WIDTH(A_VW), .COUNT_WIDTH(A_CW), .DATA_WIDTH(A_DW)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .flush(a_flush), .flush_done(a_flush_done), .full(a_full),
    .enqueue(a_enqueue), .data_out(a_data_out), .busy(a_busy)
  );

  rle_packer #(.VALUE_WIDTH(B_VW), .COUNT_WIDTH(B_CW), .DATA_WIDTH(B_DW)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .flush(b_flush), .flush_done(b_flush_done), .full(b_full),
    .enqueue(b_enqueue), .data_out(b_data_out), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs just after the rising edge, returns at the falling edge
  task automatic applyStimulus(input bit sel_b, input logic v, input logic [27:0] d,
                               input logic fl, input logic fu);
    @(posedge clk);
    #1;
    if (sel_b) begin
      b_in_valid = v; b_in_data = d; b_flush = fl; b_full = fu;
    end else begin
      a_in_valid = v; a_in_data = d[15:0]; a_flush = fl; a_full = fu;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 28'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    compared = 0; mismatched = 0;
    reset = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_flush = 0; a_full = 0;
    b_in_valid = 0; b_in_data = '0; b_flush = 0; b_full = 0;

    fork
      forever begin
        @(negedge clk);
        if (a_enqueue) begin
          if (qa.size() == 0) checkOutput("a_word_was_expected", 32'(qa.size()), 32'd1);
          else checkOutput("a_word", a_data_out, qa.pop_front());
        end
        if (b_enqueue) begin
          if (qb.size() == 0) checkOutput("b_word_was_expected", 32'(qb.size()), 32'd1);
          else checkOutput("b_word", b_data_out, qb.pop_front());
        end
        if (a_full) checkOutput("a_no_strobe_when_full", 32'(a_enqueue), 32'd0);
      end
    join_none

    // Reset state
    idle(2);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_enqueue", 32'(a_enqueue), 32'd0);
    checkOutput("reset_in_ready", 32'(a_in_ready), 32'd1);
    checkOutput("reset_flush_done", 32'(a_flush_done), 32'd0);
    checkOutput("reset_busy", 32'(a_busy), 32'd0);
    checkOutput("reset_data_out", a_data_out, 32'd0);
    checkOutput("reset_b_busy", 32'(b_busy), 32'd0);

    // 5,5,5,7 then flush
    qa.push_back(32'h0005_0003);
    qa.push_back(32'h0007_0001);
    applyStimulus(1'b0, 1'b1, 28'h5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 28'h5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 28'h5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 28'h7, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b1, 1'b0);
    checkOutput("t1_flush_done", 32'(a_flush_done), 32'd1);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b0, 1'b0);
    checkOutput("t1_flush_done_once", 32'(a_flush_done), 32'd0);
    idle(3);
    checkOutput("t1_idle_busy", 32'(a_busy), 32'd0);

    // 3,4 then FIFO full for 5 cycles with a third input held
    qa.push_back(32'h0003_0001);
    qa.push_back(32'h0004_0001);
    qa.push_back(32'h0005_0001);
    applyStimulus(1'b0, 1'b1, 28'h3, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 28'h4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 28'h5, 1'b0, 1'b1);
      checkOutput("t2_in_ready_full", 32'(a_in_ready), 32'd0);
      checkOutput("t2_enqueue_full", 32'(a_enqueue), 32'd0);
      checkOutput("t2_data_stable", a_data_out, 32'h0003_0001);
    end
    applyStimulus(1'b0, 1'b1, 28'h5, 1'b0, 1'b0);
    checkOutput("t2_in_ready_release", 32'(a_in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b1, 1'b0);
    checkOutput("t2_flush_done", 32'(a_flush_done), 32'd1);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b0, 1'b0);
    idle(3);

    // Value 0 run
    qa.push_back(32'h0000_0002);
    applyStimulus(1'b0, 1'b1, 28'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 28'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b1, 1'b0);
    checkOutput("t4_flush_done", 32'(a_flush_done), 32'd1);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b0, 1'b0);
    idle(3);

    // Reset mid-run discards the open run of 6s
    applyStimulus(1'b0, 1'b1, 28'h6, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 28'h6, 1'b0, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1; a_in_valid = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("t5_busy_after_reset", 32'(a_busy), 32'd0);
    checkOutput("t5_enqueue_after_reset", 32'(a_enqueue), 32'd0);
    qa.push_back(32'h0008_0001);
    applyStimulus(1'b0, 1'b1, 28'h8, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b0, 1'b0);
    idle(3);

    // Flush with no run, held flush, and flush deferred by a valid input
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b1, 1'b0);
    checkOutput("t6_flush_empty_done", 32'(a_flush_done), 32'd1);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b1, 1'b0);
    checkOutput("t6_flush_held_done", 32'(a_flush_done), 32'd1);
    qa.push_back(32'h0011_0001);
    applyStimulus(1'b0, 1'b1, 28'h11, 1'b1, 1'b0);
    checkOutput("t6_flush_waits_input", 32'(a_flush_done), 32'd0);
    checkOutput("t6_in_ready_with_flush", 32'(a_in_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b1, 1'b0);
    checkOutput("t6_flush_done_late", 32'(a_flush_done), 32'd1);
    applyStimulus(1'b0, 1'b0, 28'h0, 1'b0, 1'b0);
    checkOutput("t6_flush_dropped", 32'(a_flush_done), 32'd0);

    // Narrow count: 16 nines saturate at 15
    qb.push_back(32'h0000_009F);
    qb.push_back(32'h0000_0091);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b1, 28'h9, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 28'h0, 1'b1, 1'b0);
    checkOutput("t3_flush_done", 32'(b_flush_done), 32'd1);
    applyStimulus(1'b1, 1'b0, 28'h0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      idle(1);
    end
    idle(2);
    checkOutput("a_scoreboard_drained", 32'(qa.size()), 32'd0);
    checkOutput("b_scoreboard_drained", 32'(qb.size()), 32'd0);
    checkOutput("a_final_busy", 32'(a_busy), 32'd0);
    checkOutput("b_final_busy", 32'(b_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
